motion_accumulator: RTL and testbench

Consumes the pause state and Q1.2 step size from the speed controller and turns them into a per-frame pattern offset. Detects the VGA vsync rising edge and advances a fixed-point position accumulator once per frame when not paused. Supports wrap-around mode and ping-pong (bounce) mode. Sits between the speed controller and the pattern generators, which read the integer `offset` and the `dir` flag.

---
 rtl/pattern_pkg.sv | 18 +
 rtl/rising_edge_detect.sv | 21 ++
 rtl/motion_accumulator.sv | 109 ++++++++++
 tb/tb_motion_accumulator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared constants and types for the pattern pipeline: fixed-point format of the
// speed controller's step, direction encoding and default axis periods.
package pattern_pkg;

    localparam int FRAC_BITS = 2;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int H_LIMIT = 640;
    localparam int V_LIMIT = 480;

    typedef enum logic {
        ST_FWD = DIR_FWD,
        ST_REV = DIR_REV
    } motion_state_e;

endpackage

// File: rtl/rising_edge_detect.sv
// Single-cycle pulse on a low-to-high transition of a clk-synchronous level.
// RST_VAL seeds the delayed copy so a level already high at reset release can be ignored.
module rising_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= RST_VAL;
        else        r_q <= d;
    end

    assign pulse = d & ~r_q;

endmodule

// File: rtl/motion_accumulator.sv
// Per-frame fixed-point position accumulator driving the pattern offset.
// Advances once per vsync rising edge in wrap or ping-pong mode unless paused.
module motion_accumulator
    import pattern_pkg::*;
#(
    parameter int POS_BITS = 10,
    parameter int LIMIT    = H_LIMIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vsync,
    input  logic                paused,
    input  logic [2:0]          step_size,
    input  logic                bounce,
    output logic [POS_BITS-1:0] offset,
    output logic                dir,
    output logic                frame_tick,
    output logic                wrapped
);

    localparam int ACC_W = POS_BITS + FRAC_BITS;
    localparam int EXT_W = POS_BITS + 3;
    localparam logic [EXT_W-1:0] FULL    = EXT_W'(LIMIT * 4);
    localparam logic [EXT_W-1:0] LAST_PX = EXT_W'(LIMIT * 4 - 4);

    logic          w_strobe;
    logic          w_update;
    logic [EXT_W-1:0] w_acc_ext;
    logic [EXT_W-1:0] w_step_ext;
    logic [EXT_W-1:0] w_sum;
    logic [EXT_W-1:0] w_diff;

    motion_state_e r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic          r_tick, w_tick_nxt;
    logic          r_wrap, w_wrap_nxt;

    // Delayed vsync resets high so a vsync already asserted at release is not an edge.
    rising_edge_detect #(
        .RST_VAL (1'b1)
    ) u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vsync),
        .pulse (w_strobe)
    );

    assign w_update   = w_strobe & ~paused;
    assign w_acc_ext  = {1'b0, r_acc};
    assign w_step_ext = EXT_W'(step_size);
    assign w_sum      = w_acc_ext + w_step_ext;
    assign w_diff     = w_acc_ext - w_step_ext;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_tick_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (w_update) begin
            w_tick_nxt = 1'b1;
            if (!bounce) begin
                w_state_nxt = ST_FWD;
                if (w_sum >= FULL) begin
                    w_acc_nxt  = ACC_W'(w_sum - FULL);
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_acc_nxt  = ACC_W'(w_sum);
                end
            end else if (r_state == ST_FWD) begin
                // Clamp on the last whole pixel so the reflection shows LIMIT-1 exactly.
                if (w_sum >= LAST_PX) begin
                    w_acc_nxt   = ACC_W'(LAST_PX);
                    w_state_nxt = ST_REV;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_acc_nxt   = ACC_W'(w_sum);
                end
            end else begin
                if (w_acc_ext <= w_step_ext) begin
                    w_acc_nxt   = '0;
                    w_state_nxt = ST_FWD;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_acc_nxt   = ACC_W'(w_diff);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FWD;
            r_acc   <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_tick  <= w_tick_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign offset     = r_acc[ACC_W-1:FRAC_BITS];
    assign dir        = (r_state == ST_REV) ? DIR_REV : DIR_FWD;
    assign frame_tick = r_tick;
    assign wrapped    = r_wrap;

endmodule

// File: tb/tb_motion_accumulator.sv
// Directed bench for motion_accumulator: per-frame stepping, pause, wrap, bounce
// and vsync/reset edge cases, with hand-computed expectations.
module tb_motion_accumulator;

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic       paused;
    logic [2:0] step_size;
    logic       bounce;
    logic [9:0] offset;
    logic       dir;
    logic       frame_tick;
    logic       wrapped;

    int checks = 0;
    int errors = 0;

    motion_accumulator #(
        .POS_BITS (10),
        .LIMIT    (640)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .paused     (paused),
        .step_size  (step_size),
        .bounce     (bounce),
        .offset     (offset),
        .dir        (dir),
        .frame_tick (frame_tick),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; vsync = 1'b0; paused = 1'b0; step_size = 3'd0; bounce = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One low-then-high vsync; outputs sampled in the cycle after the strobe.
    task automatic vs_edge(input logic [2:0] st, input logic p, output logic ft, output logic wr);
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1; step_size = st; paused = p;
        @(negedge clk);
        ft = frame_tick;
        wr = wrapped;
    endtask

    task automatic run_edges(input int n, input logic [2:0] st);
        logic ft, wr;
        for (int i = 0; i < n; i++) vs_edge(st, 1'b0, ft, wr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b0; paused = 1'b0; step_size = 3'd0; bounce = 1'b0;
        #3;
        checks++; if (offset !== 10'd0) begin errors++; $display("FAIL reset_offset got %0d exp 0", offset); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %b exp 0", dir); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %b exp 0", wrapped); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_step4();
        logic ft, wr;
        for (int i = 1; i <= 3; i++) begin
            vs_edge(3'd4, 1'b0, ft, wr);
            checks++; if (offset !== 10'(i)) begin errors++; $display("FAIL step4_offset[%0d] got %0d exp %0d", i, offset, i); end
            checks++; if (ft !== 1'b1) begin errors++; $display("FAIL step4_tick[%0d] got %b exp 1", i, ft); end
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL step4_wrapped[%0d] got %b exp 0", i, wr); end
            @(negedge clk);
            checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL step4_tick_width[%0d] got %b exp 0", i, frame_tick); end
        end
    endtask

    task automatic test_quarter();
        logic ft, wr;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            vs_edge(3'd1, 1'b0, ft, wr);
            checks++; if (offset !== ((i == 4) ? 10'd1 : 10'd0)) begin errors++; $display("FAIL quarter_offset[%0d] got %0d exp %0d", i, offset, (i == 4) ? 1 : 0); end
            checks++; if (ft !== 1'b1) begin errors++; $display("FAIL quarter_tick[%0d] got %b exp 1", i, ft); end
        end
    endtask

    task automatic test_pause();
        logic ft, wr;
        for (int i = 0; i < 2; i++) begin
            vs_edge(3'd4, 1'b1, ft, wr);
            checks++; if (ft !== 1'b0) begin errors++; $display("FAIL pause_tick[%0d] got %b exp 0", i, ft); end
            checks++; if (offset !== 10'd1) begin errors++; $display("FAIL pause_offset[%0d] got %0d exp 1", i, offset); end
        end
        vs_edge(3'd4, 1'b0, ft, wr);
        checks++; if (offset !== 10'd2) begin errors++; $display("FAIL unpause_offset got %0d exp 2", offset); end
        checks++; if (ft !== 1'b1) begin errors++; $display("FAIL unpause_tick got %b exp 1", ft); end
    endtask

    task automatic test_wrap();
        logic ft, wr;
        do_reset();
        run_edges(365, 3'd7);
        vs_edge(3'd1, 1'b0, ft, wr);
        checks++; if (offset !== 10'd639) begin errors++; $display("FAIL wrap_setup got %0d exp 639", offset); end
        vs_edge(3'd6, 1'b0, ft, wr);
        checks++; if (offset !== 10'd0) begin errors++; $display("FAIL wrap_offset got %0d exp 0", offset); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL wrap_wrapped got %b exp 1", wr); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL wrap_dir got %b exp 0", dir); end
        @(negedge clk);
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL wrap_pulse_width got %b exp 0", wrapped); end
        vs_edge(3'd6, 1'b0, ft, wr);
        checks++; if (offset !== 10'd2) begin errors++; $display("FAIL wrap_residue got %0d exp 2", offset); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL wrap_second_wrapped got %b exp 0", wr); end
    endtask

    task automatic test_bounce();
        logic ft, wr;
        do_reset();
        run_edges(364, 3'd7);
        vs_edge(3'd6, 1'b0, ft, wr);
        checks++; if (offset !== 10'd638) begin errors++; $display("FAIL bounce_setup got %0d exp 638", offset); end
        bounce = 1'b1;
        vs_edge(3'd4, 1'b0, ft, wr);
        checks++; if (offset !== 10'd639) begin errors++; $display("FAIL bounce_top_offset got %0d exp 639", offset); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL bounce_top_dir got %b exp 1", dir); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL bounce_top_wrapped got %b exp 1", wr); end
        @(negedge clk);
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL bounce_pulse_width got %b exp 0", wrapped); end
        vs_edge(3'd4, 1'b0, ft, wr);
        checks++; if (offset !== 10'd638) begin errors++; $display("FAIL bounce_rev_offset got %0d exp 638", offset); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL bounce_rev_wrapped got %b exp 0", wr); end
        run_edges(364, 3'd7);
        checks++; if (offset !== 10'd1 || dir !== 1'b1) begin errors++; $display("FAIL bounce_descend got off=%0d dir=%b exp off=1 dir=1", offset, dir); end
        vs_edge(3'd2, 1'b0, ft, wr);
        checks++; if (offset !== 10'd0 || wr !== 1'b0) begin errors++; $display("FAIL bounce_acc2 got off=%0d wr=%b exp off=0 wr=0", offset, wr); end
        vs_edge(3'd4, 1'b0, ft, wr);
        checks++; if (offset !== 10'd0) begin errors++; $display("FAIL bounce_floor_offset got %0d exp 0", offset); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL bounce_floor_dir got %b exp 0", dir); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL bounce_floor_wrapped got %b exp 1", wr); end
        vs_edge(3'd4, 1'b0, ft, wr);
        checks++; if (offset !== 10'd1 || dir !== 1'b0) begin errors++; $display("FAIL bounce_restart got off=%0d dir=%b exp off=1 dir=0", offset, dir); end
        bounce = 1'b0;
    endtask

    task automatic test_vsync_reset();
        int ticks;
        rst_n = 1'b0; vsync = 1'b1; paused = 1'b0; step_size = 3'd4; bounce = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 0) begin errors++; $display("FAIL vsync_high_release ticks got %0d exp 0", ticks); end
        checks++; if (offset !== 10'd0) begin errors++; $display("FAIL vsync_high_offset got %0d exp 0", offset); end
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 1) begin errors++; $display("FAIL vsync_held ticks got %0d exp 1", ticks); end
        checks++; if (offset !== 10'd1) begin errors++; $display("FAIL vsync_held_offset got %0d exp 1", offset); end
    endtask

    task automatic test_midrun_reset();
        logic ft, wr;
        do_reset();
        run_edges(364, 3'd7);
        vs_edge(3'd6, 1'b0, ft, wr);
        bounce = 1'b1;
        vs_edge(3'd4, 1'b0, ft, wr);
        checks++; if (offset !== 10'd639 || dir !== 1'b1) begin errors++; $display("FAIL midrun_setup got off=%0d dir=%b exp off=639 dir=1", offset, dir); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (offset !== 10'd0) begin errors++; $display("FAIL midrun_reset_offset got %0d exp 0", offset); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL midrun_reset_dir got %b exp 0", dir); end
        @(negedge clk);
        rst_n = 1'b1;
        bounce = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_step4();
        test_quarter();
        test_pause();
        test_wrap();
        test_bounce();
        test_vsync_reset();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
